// File: rtl/fft_result_streamer.sv
// fft_result_streamer
// Captures the FFT core's parallel Re/Im result array in one edge and replays it
// as a valid/ready stream in natural frequency order (optionally undoing the
// core's bit-reversed bin ordering). All state advances on the falling clock edge
// to line up with the FFT core.
module fft_result_streamer #(
  parameter int unsigned D_WIDTH     = 64,
  parameter int unsigned LOG_2_WIDTH = 6,
  parameter int unsigned BIT_REVERSE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [16*D_WIDTH-1:0]    in_Re,
  input  logic [16*D_WIDTH-1:0]    in_Im,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [15:0]              out_Re,
  output logic [15:0]              out_Im,
  output logic [LOG_2_WIDTH-1:0]   out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     overrun
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [LOG_2_WIDTH-1:0] LAST_K = LOG_2_WIDTH'(D_WIDTH - 1);

  state_t                 state;
  logic [LOG_2_WIDTH-1:0] k;
  logic [31:0]            frame_q [D_WIDTH];
  logic [LOG_2_WIDTH-1:0] rd_addr;
  logic                   capture;
  logic                   handshake;

  function automatic logic [LOG_2_WIDTH-1:0] bitrev(input logic [LOG_2_WIDTH-1:0] v);
    logic [LOG_2_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG_2_WIDTH; i++) begin
      r[i] = v[LOG_2_WIDTH-1-i];
    end
    return r;
  endfunction

  // Accept a new frame when idle, or on the edge that retires the final beat.
  assign in_ready  = (state == IDLE) | ((state == STREAM) & out_last & out_ready);
  assign capture   = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  // Data path: read buffer entry selected by beat counter (through bin reordering).
  assign rd_addr   = (BIT_REVERSE != 0) ? bitrev(k) : k;
  assign out_Re    = frame_q[rd_addr][31:16];
  assign out_Im    = frame_q[rd_addr][15:0];
  assign out_index = k;

  // Capture buffer: whole result array loaded in a single edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < D_WIDTH; i++) begin
        frame_q[i] <= '0;
      end
    end else if (capture) begin
      for (int unsigned i = 0; i < D_WIDTH; i++) begin
        frame_q[i] <= {in_Re[16*i +: 16], in_Im[16*i +: 16]};
      end
    end
  end

  // Stream FSM with registered valid/last/overrun; capture has priority over the
  // last-beat return to IDLE so back-to-back frames stream without a bubble.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= in_valid & ~in_ready;
      if (capture) begin
        state     <= STREAM;
        k         <= '0;
        out_valid <= 1'b1;
        out_last  <= (LAST_K == '0);
      end else if (handshake) begin
        if (out_last) begin
          state     <= IDLE;
          k         <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          k        <= k + 1'b1;
          out_last <= ((k + 1'b1) == LAST_K);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_result_streamer.sv
// tb_fft_result_streamer
// Self-checking bench for fft_result_streamer: one bit-reversing instance and one
// natural-order instance share all inputs and are compared against a frame-level
// reference model (frame copy, beat position, busy flag).
module tb_fft_result_streamer;

  localparam int N = 64;

  logic              clk;
  logic              rst;
  logic [16*N-1:0]   in_Re;
  logic [16*N-1:0]   in_Im;
  logic              in_valid;
  logic              out_ready;
  logic [15:0]       re_w [N];
  logic [15:0]       im_w [N];

  logic              in_ready_b, out_valid_b, out_last_b, overrun_b;
  logic [15:0]       out_Re_b, out_Im_b;
  logic [5:0]        out_index_b;
  logic              in_ready_n, out_valid_n, out_last_n, overrun_n;
  logic [15:0]       out_Re_n, out_Im_n;
  logic [5:0]        out_index_n;

  // reference model state
  logic [15:0]       fr_re [N];
  logic [15:0]       fr_im [N];
  int                pos;
  bit                busy;
  bit                ovr_exp;

  int                checks;
  int                errors;

  fft_result_streamer #(.D_WIDTH(64), .LOG_2_WIDTH(6), .BIT_REVERSE(1)) dut_br (
    .clk(clk), .rst(rst), .in_Re(in_Re), .in_Im(in_Im), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_Re(out_Re_b), .out_Im(out_Im_b),
    .out_index(out_index_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_last(out_last_b), .overrun(overrun_b));

  fft_result_streamer #(.D_WIDTH(64), .LOG_2_WIDTH(6), .BIT_REVERSE(0)) dut_nat (
    .clk(clk), .rst(rst), .in_Re(in_Re), .in_Im(in_Im), .in_valid(in_valid),
    .in_ready(in_ready_n), .out_Re(out_Re_n), .out_Im(out_Im_n),
    .out_index(out_index_n), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_last(out_last_n), .overrun(overrun_n));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  always_comb begin
    in_Re = '0;
    in_Im = '0;
    for (int i = 0; i < N; i++) begin
      in_Re[16*i +: 16] = re_w[i];
      in_Im[16*i +: 16] = im_w[i];
    end
  end

  // bin reversal computed arithmetically, digit by digit
  function automatic int rev6(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy    = 0;
    pos     = 0;
    ovr_exp = 0;
    for (int i = 0; i < N; i++) begin
      fr_re[i] = '0;
      fr_im[i] = '0;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", {31'b0, out_valid_b}, 0);
    chk("rst_out_last",  {31'b0, out_last_b},  0);
    chk("rst_overrun",   {31'b0, overrun_b},   0);
    chk("rst_in_ready",  {31'b0, in_ready_b},  1);
    chk("rst_out_index", {26'b0, out_index_b}, 0);
    chk("rst_out_re",    {16'b0, out_Re_b},    0);
    chk("rst_out_valid_nat", {31'b0, out_valid_n}, 0);
    chk("rst_in_ready_nat",  {31'b0, in_ready_n},  1);
  endtask

  // Called at a rising edge right after inputs are driven: checks outputs,
  // advances the model across the following falling edge, returns at next rising edge.
  task automatic tick();
    bit exp_ready;
    #1;
    exp_ready = !busy || (pos == N-1 && out_ready);
    chk("in_ready",      {31'b0, in_ready_b},  {31'b0, exp_ready});
    chk("in_ready_nat",  {31'b0, in_ready_n},  {31'b0, exp_ready});
    chk("out_valid",     {31'b0, out_valid_b}, {31'b0, busy});
    chk("out_valid_nat", {31'b0, out_valid_n}, {31'b0, busy});
    chk("out_index",     {26'b0, out_index_b}, pos);
    chk("out_index_nat", {26'b0, out_index_n}, pos);
    chk("out_last",      {31'b0, out_last_b},  {31'b0, busy && pos == N-1});
    chk("overrun",       {31'b0, overrun_b},   {31'b0, ovr_exp});
    chk("overrun_nat",   {31'b0, overrun_n},   {31'b0, ovr_exp});
    if (busy) begin
      chk("out_re",     {16'b0, out_Re_b}, {16'b0, fr_re[rev6(pos)]});
      chk("out_im",     {16'b0, out_Im_b}, {16'b0, fr_im[rev6(pos)]});
      chk("out_re_nat", {16'b0, out_Re_n}, {16'b0, fr_re[pos]});
      chk("out_im_nat", {16'b0, out_Im_n}, {16'b0, fr_im[pos]});
    end
    ovr_exp = in_valid && !exp_ready;
    if (busy && out_ready) begin
      if (pos == N-1) begin
        busy = 0;
        pos  = 0;
      end else begin
        pos++;
      end
    end
    if (in_valid && exp_ready) begin
      for (int i = 0; i < N; i++) begin
        fr_re[i] = re_w[i];
        fr_im[i] = im_w[i];
      end
      busy = 1;
      pos  = 0;
    end
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic start_frame();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic run_frame(input int ready_pct, input int budget);
    int n;
    logic [15:0] p_re, p_im;
    logic [5:0]  p_idx;
    bit          stalled;
    n = 0;
    stalled = 0;
    while (busy && n < budget) begin
      if (stalled) begin
        chk("stall_re",  {16'b0, out_Re_b},    {16'b0, p_re});
        chk("stall_im",  {16'b0, out_Im_b},    {16'b0, p_im});
        chk("stall_idx", {26'b0, out_index_b}, {26'b0, p_idx});
      end
      out_ready = ($urandom_range(99) < ready_pct);
      stalled = out_valid_b && !out_ready;
      p_re  = out_Re_b;
      p_im  = out_Im_b;
      p_idx = out_index_b;
      tick();
      n++;
    end
    chk("frame_completes", {31'b0, out_valid_b}, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      re_w[i] = '0;
      im_w[i] = '0;
    end
    model_reset();

    // reset state
    #2;
    check_reset_outputs();
    @(posedge clk);
    rst = 1'b1;
    tick();

    // ramp frame, full-rate consumer
    for (int i = 0; i < N; i++) begin
      re_w[i] = 16'(i);
      im_w[i] = 16'(-i);
    end
    start_frame();
    while (busy) begin
      if (pos == 1) begin
        chk("k1_re", {16'b0, out_Re_b}, 32);
        chk("k1_im", {16'b0, out_Im_b}, 32'h0000_FFE0);
      end
      if (pos == 2) chk("k2_re", {16'b0, out_Re_b}, 16);
      if (pos == N-1) begin
        chk("k63_re",   {16'b0, out_Re_b},   63);
        chk("k63_last", {31'b0, out_last_b}, 1);
      end
      tick();
    end
    chk("after_last_valid", {31'b0, out_valid_b}, 0);
    tick();

    // random data, random backpressure
    for (int i = 0; i < N; i++) begin
      re_w[i] = 16'($urandom);
      im_w[i] = 16'($urandom);
    end
    start_frame();
    run_frame(50, 1000);

    // overrun mid-frame, then zero-bubble handover on the last beat
    for (int i = 0; i < N; i++) begin
      re_w[i] = 16'($urandom);
      im_w[i] = 16'($urandom);
    end
    start_frame();
    while (busy && pos < 10) tick();
    for (int i = 0; i < N; i++) begin
      re_w[i] = 16'(100 + i);
      im_w[i] = 16'(200 + i);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("overrun_pulse", {31'b0, overrun_b}, 1);
    tick();
    chk("overrun_clears", {31'b0, overrun_b}, 0);
    while (busy && pos < N-1) tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("handover_valid", {31'b0, out_valid_b}, 1);
    chk("handover_index", {26'b0, out_index_b}, 0);
    chk("handover_re_nat", {16'b0, out_Re_n}, 100);
    while (busy && pos < 5) tick();
    chk("nat_k5_re", {16'b0, out_Re_n}, 105);
    chk("nat_k5_idx", {26'b0, out_index_n}, 5);
    run_frame(70, 1000);

    // asynchronous reset mid-frame
    for (int i = 0; i < N; i++) re_w[i] = 16'($urandom);
    start_frame();
    while (busy && pos < 20) tick();
    chk("pre_reset_index", {26'b0, out_index_b}, 20);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(posedge clk);
    rst = 1'b1;
    tick();
    tick();
    start_frame();
    run_frame(60, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
